// File: rtl/mul_pkg.sv
// Shared types and defaults for the pipelined multiplier.
// Mode encoding, latency and ROB tag width.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_LO  = 2'd0,
    MUL_HSS = 2'd1,
    MUL_HUU = 2'd2,
    MUL_HSU = 2'd3
  } mul_mode_t;

  localparam int MUL_LAT        = 3;
  localparam int LG_ROB_ENTRIES = 6;

  function automatic logic a_signed_of(
    input mul_mode_t m
  );
    return (m == MUL_HSS) || (m == MUL_HSU);
  endfunction

  function automatic logic b_signed_of(
    input mul_mode_t m
  );
    return m == MUL_HSS;
  endfunction

  // first row index owned by reduction stage t of ns
  function automatic int split_at(
    input int n,
    input int ns,
    input int t
  );
    return (n * t) / ns;
  endfunction

endpackage

// File: rtl/mul_pipe_param_pp_gen.sv
// Baugh-Wooley partial products for a (W+1)x(W+1) multiply.
// Cross terms inverted, +2^(W+1) folded into row 0.
module mul_pp_gen
  import mul_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  input  logic                  a_signed,
  input  logic                  b_signed,
  output logic [W:0][2*W-1:0]   rows
);

  localparam int P = 2 * W;

  logic [W:0] ae;
  logic [W:0] be;

  assign ae = {a_signed & a[W-1], a};
  assign be = {b_signed & b[W-1], b};

  // row i holds ae*be[i]; terms touching exactly one sign bit are inverted
  always_comb begin
    rows = '0;
    for (int i = 0; i <= W; i++) begin
      for (int j = 0; j <= W; j++) begin
        if (i + j < P) begin
          rows[i][i+j] = (ae[j] & be[i])
                       ^ ((i == W) != (j == W));
        end
      end
    end
    rows[0][W+1] = 1'b1;
  end

endmodule

// File: rtl/mul_pipe_param.sv
// Fully pipelined W x W multiplier with flush and ROB tag.
// CSA reduction over stages 1..LAT-1, CPA in LAT-1, output reg LAT.
module mul_pipe_param
  import mul_pkg::*;
#(
  parameter int W     = 32,
  parameter int LAT   = MUL_LAT,
  parameter int TAG_W = LG_ROB_ENTRIES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  mul_mode_t        mode,
  input  logic [W-1:0]     src_a,
  input  logic [W-1:0]     src_b,
  input  logic [TAG_W-1:0] rob_ptr_in,
  input  logic             flush,
  output logic             complete,
  output logic [TAG_W-1:0] rob_ptr_out,
  output logic [W-1:0]     y,
  output logic [2*W-1:0]   y_full
);

  localparam int P  = 2 * W;
  localparam int R  = W + 1;
  localparam int NS = LAT - 1;
  localparam int N  = R - 2;

  typedef logic [P-1:0] row_t;

  function automatic logic [2*P-1:0] csa(
    input row_t s,
    input row_t c,
    input row_t r
  );
    row_t cy;
    cy = ((s & c) | (s & r) | (c & r)) << 1;
    return {s ^ c ^ r, cy};
  endfunction

  logic                  as_in;
  logic                  bs_in;
  row_t [R-1:0]          pp;
  row_t [NS-1:0]         in_s;
  row_t [NS-1:0]         in_c;
  row_t [NS-1:0][R-1:0]  in_r;
  row_t [NS-1:0]         sum_d;
  row_t [NS-1:0]         carry_d;
  row_t [NS-1:0]         sum_q;
  row_t [NS-1:0]         carry_q;
  row_t [NS-1:0][R-1:0]  rows_q;
  row_t                  prod_d;
  row_t                  prod_q;
  row_t                  full_q;
  logic [W-1:0]          y_q;
  logic [LAT:1]          v_q;
  logic [TAG_W-1:0]      tag_q [1:LAT];
  mul_mode_t             mode_q [1:LAT-1];
  logic                  unused_tail;

  assign as_in = a_signed_of(mode);
  assign bs_in = b_signed_of(mode);

  mul_pp_gen #(.W(W)) u_pp (
    .a        (src_a),
    .b        (src_b),
    .a_signed (as_in),
    .b_signed (bs_in),
    .rows     (pp)
  );

  // stage 0 reads fresh rows; later stages read the previous register
  always_comb begin
    in_s = '0;
    in_c = '0;
    in_r = '0;
    in_s[0] = pp[0];
    in_c[0] = pp[1];
    in_r[0] = pp;
    for (int t = 1; t < NS; t++) begin
      in_s[t] = sum_q[t-1];
      in_c[t] = carry_q[t-1];
      in_r[t] = rows_q[t-1];
    end
  end

  // each stage folds its own slice of rows into sum/carry
  always_comb begin
    row_t s;
    row_t c;
    logic [2*P-1:0] sc;
    s = '0;
    c = '0;
    sc = '0;
    sum_d = '0;
    carry_d = '0;
    for (int t = 0; t < NS; t++) begin
      s = in_s[t];
      c = in_c[t];
      for (int r = 2; r < R; r++) begin
        if (r >= 2 + split_at(N, NS, t) &&
            r <  2 + split_at(N, NS, t + 1)) begin
          sc = csa(s, c, in_r[t][r]);
          s  = sc[2*P-1:P];
          c  = sc[P-1:0];
        end
      end
      sum_d[t]   = s;
      carry_d[t] = c;
    end
  end

  assign prod_d = sum_d[NS-1] + carry_d[NS-1];

  // the last stage's sum/carry/rows are superseded by prod_q
  assign unused_tail = ^{sum_q[NS-1], carry_q[NS-1], rows_q[NS-1]};

  // data advances every cycle; only valids are gated by flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q   <= '0;
      carry_q <= '0;
      rows_q  <= '0;
      prod_q  <= '0;
      full_q  <= '0;
      y_q     <= '0;
      v_q     <= '0;
      for (int i = 1; i <= LAT; i++) tag_q[i] <= '0;
      for (int i = 1; i < LAT; i++) mode_q[i] <= MUL_LO;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      rows_q  <= in_r;
      prod_q  <= prod_d;
      full_q  <= prod_q;
      y_q     <= (mode_q[LAT-1] == MUL_LO) ? prod_q[W-1:0]
                                           : prod_q[P-1:W];
      v_q     <= flush ? '0 : {v_q[LAT-1:1], go};
      tag_q[1]  <= rob_ptr_in;
      mode_q[1] <= mode;
      for (int i = 2; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
      for (int i = 2; i < LAT; i++) mode_q[i] <= mode_q[i-1];
    end
  end

  assign complete    = v_q[LAT];
  assign rob_ptr_out = tag_q[LAT];
  assign y           = y_q;
  assign y_full      = full_q;

endmodule

// File: tb/tb_mul_pipe_param.sv
// Bench for mul_pipe_param: W=32/LAT=3 directed, W=64/LAT=4 random.
// Reference uses wide two's-complement arithmetic and an op queue.
module tb_mul_pipe_param;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        go32, fl32, c32;
  mul_mode_t   m32;
  logic [31:0] a32, b32, y32;
  logic [5:0]  ti32, t32;
  logic [63:0] f32;

  logic        go64, fl64, c64;
  mul_mode_t   m64;
  logic [63:0] a64, b64, y64;
  logic [5:0]  ti64, t64;
  logic [127:0] f64;

  int n_tests = 0;
  int n_fail  = 0;

  mul_pipe_param #(.W(32), .LAT(3), .TAG_W(6)) dut32 (
    .clk(clk), .reset(rst_n), .go(go32), .mode(m32),
    .src_a(a32), .src_b(b32), .rob_ptr_in(ti32),
    .flush(fl32), .complete(c32), .rob_ptr_out(t32),
    .y(y32), .y_full(f32)
  );

  mul_pipe_param #(.W(64), .LAT(4), .TAG_W(6)) dut64 (
    .clk(clk), .reset(rst_n), .go(go64), .mode(m64),
    .src_a(a64), .src_b(b64), .rob_ptr_in(ti64),
    .flush(fl64), .complete(c64), .rob_ptr_out(t64),
    .y(y64), .y_full(f64)
  );

  function automatic logic [127:0] ref_full(
    input logic [63:0] a, input logic [63:0] b,
    input mul_mode_t m, input int w
  );
    logic signed [129:0] ea, eb, p;
    logic sa, sb;
    sa = (m == MUL_HSS) || (m == MUL_HSU);
    sb = (m == MUL_HSS);
    if (w == 32) begin
      ea = sa ? {{98{a[31]}}, a[31:0]} : {98'b0, a[31:0]};
      eb = sb ? {{98{b[31]}}, b[31:0]} : {98'b0, b[31:0]};
    end else begin
      ea = sa ? {{66{a[63]}}, a} : {66'b0, a};
      eb = sb ? {{66{b[63]}}, b} : {66'b0, b};
    end
    p = ea * eb;
    return (w == 32) ? {64'b0, p[63:0]} : p[127:0];
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return 64'h1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive32(
    input logic g, input mul_mode_t m,
    input logic [31:0] a, input logic [31:0] b,
    input logic [5:0] t, input logic f
  );
    go32 = g; m32 = m; a32 = a; b32 = b; ti32 = t; fl32 = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_tests += 2;
    if ({c32, t32, y32, f32} !== '0) begin
      n_fail++;
      $display("FAIL reset32: got c=%0b t=%0h y=%0h f=%0h want 0",
               c32, t32, y32, f32);
    end
    if ({c64, t64, y64, f64} !== '0) begin
      n_fail++;
      $display("FAIL reset64: got c=%0b t=%0h y=%0h f=%0h want 0",
               c64, t64, y64, f64);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hss_ones();
    drive32(1, MUL_HSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd5, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      drive32(0, MUL_LO, 0, 0, 0, 0);
      n_tests++;
      if (c32 !== (i == 2)) begin
        n_fail++;
        $display("FAIL hss_complete@%0d: got %0b want %0b", i, c32, i == 2);
      end
      if (i == 2) begin
        n_tests++;
        if (f32 !== 64'h1 || y32 !== 32'h0 || t32 !== 6'd5) begin
          n_fail++;
          $display("FAIL hss_data: got f=%0h y=%0h t=%0d want 1 0 5",
                   f32, y32, t32);
        end
      end
    end
  endtask

  task automatic test_huu_hsu();
    drive32(1, MUL_HUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7, 0);
    step();
    drive32(1, MUL_HSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd8, 0);
    step();
    drive32(0, MUL_LO, 0, 0, 0, 0);
    step();
    n_tests++;
    if (c32 !== 1'b1 || f32 !== 64'hFFFF_FFFE_0000_0001 ||
        y32 !== 32'hFFFF_FFFE || t32 !== 6'd7) begin
      n_fail++;
      $display("FAIL huu: got c=%0b f=%0h y=%0h t=%0d want 1 fffffffe00000001 fffffffe 7",
               c32, f32, y32, t32);
    end
    step();
    n_tests++;
    if (c32 !== 1'b1 || f32 !== 64'hFFFF_FFFF_0000_0001 ||
        y32 !== 32'hFFFF_FFFF || t32 !== 6'd8) begin
      n_fail++;
      $display("FAIL hsu: got c=%0b f=%0h y=%0h t=%0d want 1 ffffffff00000001 ffffffff 8",
               c32, f32, y32, t32);
    end
    step();
  endtask

  task automatic test_back_to_back();
    mul_mode_t   md [4] = '{MUL_LO, MUL_HSS, MUL_HUU, MUL_LO};
    logic [31:0] av [4] = '{32'd3, 32'h8000_0000, 32'h1_0000, 32'hFFFF_FFFF};
    logic [31:0] bv [4] = '{32'd7, 32'h8000_0000, 32'h1_0000, 32'd2};
    logic [31:0] ye [4] = '{32'd21, 32'h4000_0000, 32'h1, 32'hFFFF_FFFE};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive32(1, md[i], av[i], bv[i], 6'(10 + i), 0);
      else drive32(0, MUL_LO, 0, 0, 0, 0);
      step();
      n_tests++;
      if (c32 !== (i >= 2 && i <= 5)) begin
        n_fail++;
        $display("FAIL b2b_complete@%0d: got %0b", i, c32);
      end else if (i >= 2 && i <= 5) begin
        n_tests++;
        if (y32 !== ye[i-2] || t32 !== 6'(8 + i)) begin
          n_fail++;
          $display("FAIL b2b_data@%0d: got y=%0h t=%0d want y=%0h t=%0d",
                   i, y32, t32, ye[i-2], 8 + i);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [127:0] e;
    e = ref_full(64'h1234_5678, 64'h9ABC_DEF0, MUL_HUU, 32);
    for (int i = 0; i < 8; i++) begin
      case (i)
        0, 1: drive32(1, MUL_HSS, 32'h55, 32'h66, 6'(20 + i), 0);
        2: drive32(1, MUL_HSS, 32'h77, 32'h88, 6'd22, 1);
        3: drive32(1, MUL_HUU, 32'h1234_5678, 32'h9ABC_DEF0, 6'd23, 0);
        default: drive32(0, MUL_LO, 0, 0, 0, 0);
      endcase
      step();
      n_tests++;
      if (c32 !== (i == 5)) begin
        n_fail++;
        $display("FAIL flush_complete@%0d: got %0b want %0b", i, c32, i == 5);
      end else if (i == 5) begin
        n_tests++;
        if (f32 !== e[63:0] || y32 !== e[63:32] || t32 !== 6'd23) begin
          n_fail++;
          $display("FAIL flush_data: got f=%0h t=%0d want f=%0h t=23",
                   f32, t32, e[63:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive32(1, MUL_LO, 32'd5, 32'd6, 6'd9, 0);
    step();
    drive32(0, MUL_LO, 0, 0, 0, 0);
    step();
    step();
    n_tests++;
    if (c32 !== 1'b1 || y32 !== 32'd30) begin
      n_fail++;
      $display("FAIL pre_reset: got c=%0b y=%0d want 1 30", c32, y32);
    end
    drive32(1, MUL_HUU, 32'hABCD, 32'h1234, 6'd11, 0);
    step();
    drive32(1, MUL_HSS, 32'hDEAD, 32'hBEEF, 6'd12, 0);
    step();
    drive32(0, MUL_LO, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({c32, t32, y32, f32} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got c=%0b t=%0h y=%0h f=%0h want 0",
               c32, t32, y32, f32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (c32 !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset@%0d: got complete %0b want 0", i, c32);
      end
    end
  endtask

  typedef struct {
    int           due;
    logic [127:0] full;
    logic [63:0]  y;
    logic [5:0]   tag;
  } exp_t;

  task automatic test_random64();
    exp_t q[$];
    logic [127:0] e;
    logic exp_c;
    int nops = 3000;
    for (int i = 0; i < nops + 4; i++) begin
      go64 = (i < nops) && ($urandom_range(0, 3) != 0);
      fl64 = (i < nops) && ($urandom_range(0, 31) == 0);
      m64  = mul_mode_t'(2'($urandom_range(0, 3)));
      a64  = pick64();
      b64  = pick64();
      ti64 = 6'($urandom);
      if (fl64) q.delete();
      else if (go64) begin
        e = ref_full(a64, b64, m64, 64);
        q.push_back('{i + 3, e,
                      (m64 == MUL_LO) ? e[63:0] : e[127:64], ti64});
      end
      step();
      exp_c = (q.size() > 0) && (q[0].due == i);
      n_tests++;
      if (c64 !== exp_c) begin
        n_fail++;
        $display("FAIL rand_complete@%0d: got %0b want %0b", i, c64, exp_c);
      end
      if (exp_c) begin
        n_tests++;
        if (f64 !== q[0].full || y64 !== q[0].y || t64 !== q[0].tag) begin
          n_fail++;
          $display("FAIL rand_data@%0d: got f=%0h t=%0d want f=%0h t=%0d",
                   i, f64, t64, q[0].full, q[0].tag);
        end
        void'(q.pop_front());
      end
    end
    go64 = 0;
    fl64 = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive32(0, MUL_LO, 0, 0, 0, 0);
    go64 = 0; fl64 = 0; m64 = MUL_LO;
    a64 = 0; b64 = 0; ti64 = 0;
    test_reset();
    @(negedge clk);
    test_hss_ones();
    test_huu_hsu();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random64();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
